// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types, limits and saturation helper for the variable-cutoff filter
package filter_pkg;

  typedef enum logic {
    FILT_LP = 1'b0,
    FILT_HP = 1'b1
  } filt_mode_e;

  // Intermediate width used by the saturation helpers; any sample width up to 63 fits.
  localparam int SAT_W = 64;

  localparam int                  DEF_BITWIDTH = 16;
  localparam logic signed [15:0]  DEF_MAX      = 16'sh7FFF;
  localparam logic signed [15:0]  DEF_MIN      = 16'sh8000;

  function automatic logic signed [SAT_W-1:0] sat_max(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

  // Clamp a sign-extended value to the signed range of a bw-bit sample.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v, input int bw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = sat_max(bw);
    lo = sat_min(bw);
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/phase_tick.sv
// rtl/phase_tick.sv - phase accumulator whose carry-out is the filter update tick
module phase_tick #(
  parameter int PA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                n_RST,
  input  logic [PA_WIDTH-1:0] tuning_word,
  output logic                tick
);

  logic [PA_WIDTH-1:0] r_pa;
  logic [PA_WIDTH:0]   w_sum;

  // The tick is the carry of the add that lands at the coming edge.
  assign w_sum = {1'b0, r_pa} + {1'b0, tuning_word};
  assign tick  = w_sum[PA_WIDTH];

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_pa <= '0;
    end else begin
      r_pa <= w_sum[PA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mc_var_filter.sv
// rtl/mc_var_filter.sv - multi-channel one-pole LP/HP filter with tick-gated leaky updates
module mc_var_filter
  import filter_pkg::*;
#(
  parameter  int BITWIDTH = 16,
  parameter  int CHANNELS = 4,
  parameter  int PA_WIDTH = 8,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int KW       = $clog2(BITWIDTH)
) (
  input  logic                       clk,
  input  logic                       n_RST,
  input  logic [PA_WIDTH-1:0]        tuning_word,
  input  logic [KW-1:0]              shift,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CW-1:0]              in_ch,
  input  logic signed [BITWIDTH-1:0] sig_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_ch,
  output logic signed [BITWIDTH-1:0] sig_out
);

  logic                       w_tick;
  logic signed [BITWIDTH-1:0] r_state [CHANNELS];
  logic [CHANNELS-1:0]        r_pend;
  logic [CHANNELS-1:0]        w_pend_nxt;
  logic                       r_out_valid;
  logic [CW-1:0]              r_out_ch;
  logic signed [BITWIDTH-1:0] r_sig_out;

  logic                       w_accept;
  logic                       w_in_range;
  logic                       w_take;
  logic                       w_pend_c;
  logic                       w_consume;
  logic signed [BITWIDTH-1:0] w_s;
  logic signed [BITWIDTH:0]   w_s_ext;
  logic signed [BITWIDTH:0]   w_x_ext;
  logic signed [BITWIDTH:0]   w_diff;
  logic signed [BITWIDTH:0]   w_step;
  logic signed [BITWIDTH:0]   w_sum;
  logic signed [BITWIDTH-1:0] w_upd;
  logic signed [BITWIDTH-1:0] w_sp;
  logic signed [BITWIDTH:0]   w_hp_diff;
  logic signed [BITWIDTH-1:0] w_hp;
  logic signed [BITWIDTH-1:0] w_out;

  phase_tick #(
    .PA_WIDTH(PA_WIDTH)
  ) u_phase_tick (
    .clk        (clk),
    .n_RST      (n_RST),
    .tuning_word(tuning_word),
    .tick       (w_tick)
  );

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_in_range = (int'(in_ch) < CHANNELS);
  assign w_take     = w_accept && w_in_range;
  assign w_pend_c   = w_in_range && r_pend[in_ch];
  assign w_consume  = w_take && w_pend_c;

  // Datapath runs at BITWIDTH+1 so the difference and the high-pass residue never wrap.
  assign w_s       = w_in_range ? r_state[in_ch] : '0;
  assign w_s_ext   = (BITWIDTH+1)'(w_s);
  assign w_x_ext   = (BITWIDTH+1)'(sig_in);
  assign w_diff    = w_x_ext - w_s_ext;
  assign w_step    = w_diff >>> shift;
  assign w_sum     = w_s_ext + w_step;
  assign w_upd     = BITWIDTH'(sat(SAT_W'(w_sum), BITWIDTH));
  assign w_sp      = w_pend_c ? w_upd : w_s;
  assign w_hp_diff = w_x_ext - (BITWIDTH+1)'(w_sp);
  assign w_hp      = BITWIDTH'(sat(SAT_W'(w_hp_diff), BITWIDTH));
  assign w_out     = (filt_mode_e'(mode) == FILT_HP) ? w_hp : w_sp;

  // A tick landing on the same edge as a consuming accept re-arms the flag.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int c = 0; c < CHANNELS; c++) begin
      w_pend_nxt[c] = w_tick || (r_pend[c] && !(w_consume && (in_ch == CW'(c))));
    end
  end

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_pend <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c] <= '0;
      end
    end else begin
      r_pend <= w_pend_nxt;
      if (w_consume) begin
        r_state[in_ch] <= w_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge n_RST) begin
    if (!n_RST) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_sig_out   <= '0;
    end else if (in_ready) begin
      r_out_valid <= w_take;
      if (w_take) begin
        r_out_ch  <= in_ch;
        r_sig_out <= w_out;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign sig_out   = r_sig_out;

endmodule

// File: tb/tb_mc_var_filter.sv
// tb/tb_mc_var_filter.sv - randomized self-checking bench with a behavioural filter model
module tb_mc_var_filter;

  localparam int BW = 16;
  localparam int CH = 4;
  localparam int PW = 8;

  logic                 clk = 1'b0;
  logic                 n_RST = 1'b0;
  logic [PW-1:0]        tuning_word = '0;
  logic [3:0]           shift = '0;
  logic                 mode = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [1:0]           in_ch = '0;
  logic signed [BW-1:0] sig_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [1:0]           out_ch;
  logic signed [BW-1:0] sig_out;

  int errors = 0;
  int checks = 0;

  int m_pa;
  bit m_pend [CH];
  int m_state [CH];
  bit m_valid;
  int m_sig;
  int m_ch;

  mc_var_filter #(.BITWIDTH(BW), .CHANNELS(CH), .PA_WIDTH(PW)) dut (
    .clk        (clk),
    .n_RST      (n_RST),
    .tuning_word(tuning_word),
    .shift      (shift),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .sig_in     (sig_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .sig_out    (sig_out)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div(input int d, input int p);
    int q;
    q = d / p;
    if ((d % p != 0) && (d < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_pa = 0;
    m_valid = 0;
    m_sig = 0;
    m_ch = 0;
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0;
      m_state[i] = 0;
    end
  endtask

  // Advance the reference one clock using the inputs currently driven, then wait for the DUT edge.
  task automatic step();
    int c, s, sp, x;
    bit tick, acc, cons;
    tick = (m_pa + int'(tuning_word)) >= 256;
    acc  = in_valid && (!m_valid || out_ready);
    cons = 0;
    c    = int'(in_ch);
    if (!m_valid || out_ready) m_valid = acc;
    if (acc) begin
      s  = m_state[c];
      x  = int'(sig_in);
      sp = s;
      if (m_pend[c]) begin
        sp = clamp(s + floor_div(x - s, 1 << int'(shift)));
        m_state[c] = sp;
        cons = 1;
      end
      m_sig = mode ? clamp(x - sp) : sp;
      m_ch  = c;
    end
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = tick || (m_pend[i] && !(cons && i == c));
    end
    m_pa = (m_pa + int'(tuning_word)) % 256;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int ch, input int x, input int k, input bit md);
    in_ch    = 2'(ch);
    sig_in   = 16'(x);
    shift    = 4'(k);
    mode     = md;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++;
    if (sig_out !== 16'sd0) begin errors++; $display("FAIL reset_sig: got %0d expected 0", sig_out); end
    #2;
    n_RST = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
    tuning_word = 8'd0;
    out_ready = 1'b0;
    send(0, 123, 1, 0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0b expected 1", out_valid); end
    #2;
    n_RST = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || sig_out !== 16'sd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%0b sig=%0d ready=%0b expected 0/0/1", out_valid, sig_out, in_ready);
    end
    @(posedge clk);
    #3;
    n_RST = 1'b1;
    out_ready = 1'b1;
    send(0, 777, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || sig_out !== 16'sd0 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_first: valid=%0b sig=%0d ch=%0d expected 1/0/0", out_valid, sig_out, out_ch);
    end
  endtask

  task automatic test_lp_step();
    int lp_exp [4];
    lp_exp = '{500, 750, 875, 937};
    tuning_word = 8'd128;
    for (int i = 0; i < 4; i++) begin
      idle(2);
      send(0, 1000, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || sig_out !== 16'(lp_exp[i])) begin
        errors++;
        $display("FAIL lp_step[%0d]: got %0d valid=%0b expected %0d", i, sig_out, out_valid, lp_exp[i]);
      end
    end
  endtask

  task automatic test_frozen();
    tuning_word = 8'd0;
    send(2, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      send(2, 5000, 1, 0);
      checks++;
      if (sig_out !== 16'sd0 || out_ch !== 2'd2) begin
        errors++;
        $display("FAIL frozen_lp[%0d]: got %0d ch=%0d expected 0 ch=2", i, sig_out, out_ch);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send(2, 5000, 1, 1);
      checks++;
      if (sig_out !== 16'sd5000) begin
        errors++;
        $display("FAIL frozen_hp[%0d]: got %0d expected 5000", i, sig_out);
      end
    end
  endtask

  task automatic test_hp_sat();
    tuning_word = 8'd128;
    idle(2);
    tuning_word = 8'd0;
    send(1, -20000, 0, 0);
    checks++;
    if (sig_out !== -16'sd20000) begin errors++; $display("FAIL hp_setup: got %0d expected -20000", sig_out); end
    tuning_word = 8'd128;
    idle(2);
    tuning_word = 8'd0;
    send(1, 30000, 4, 1);
    checks++;
    if (sig_out !== 16'sd32767) begin errors++; $display("FAIL hp_sat: got %0d expected 32767", sig_out); end
    send(1, 0, 4, 0);
    checks++;
    if (sig_out !== -16'sd16875) begin errors++; $display("FAIL hp_state: got %0d expected -16875", sig_out); end
  endtask

  task automatic test_back_to_back();
    logic signed [BW-1:0] held;
    tuning_word = 8'd0;
    send(0, 50, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || sig_out !== 16'(m_sig)) begin
      errors++;
      $display("FAIL bp_first: got %0d expected %0d", sig_out, m_sig);
    end
    held = sig_out;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ch = 2'd3;
    sig_in = 16'sd111;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b expected 0", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || sig_out !== held || out_ch !== 2'd0) begin
        errors++;
        $display("FAIL bp_stable[%0d]: valid=%0b sig=%0d ch=%0d expected 1/%0d/0", i, out_valid, sig_out, out_ch, held);
      end
    end
    out_ready = 1'b1;
    tuning_word = 8'd128;
    for (int i = 0; i < 40; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_ch     = (i % 2 == 0) ? 2'd0 : 2'd3;
      sig_in    = 16'($urandom);
      shift     = 4'($urandom_range(15));
      mode      = 1'($urandom_range(1));
      out_ready = ($urandom_range(4) != 0);
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL il_ready[%0d]: got %0b expected %0b", i, in_ready, (!m_valid || out_ready));
      end
      step();
      checks++;
      if (out_valid !== m_valid || (m_valid && (sig_out !== 16'(m_sig) || out_ch !== 2'(m_ch)))) begin
        errors++;
        $display("FAIL il_out[%0d]: valid=%0b sig=%0d ch=%0d expected %0b/%0d/%0d", i, out_valid, sig_out, out_ch, m_valid, m_sig, m_ch);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_tick_coincide();
    int guard;
    tuning_word = 8'd128;
    idle(2);
    tuning_word = 8'd0;
    send(0, 1000, 0, 0);
    checks++;
    if (sig_out !== 16'sd1000) begin errors++; $display("FAIL tc_setup: got %0d expected 1000", sig_out); end
    tuning_word = 8'd128;
    guard = 0;
    while (!(m_pend[0] && m_pa >= 128) && guard < 16) begin
      idle(1);
      guard++;
    end
    checks++;
    if (guard >= 16) begin errors++; $display("FAIL tc_align: no aligned tick within %0d cycles expected <16", guard); end
    send(0, 3000, 1, 0);
    checks++;
    if (sig_out !== 16'sd2000) begin errors++; $display("FAIL tc_consume: got %0d expected 2000", sig_out); end
    tuning_word = 8'd0;
    send(0, 3000, 1, 0);
    checks++;
    if (sig_out !== 16'sd2500) begin errors++; $display("FAIL tc_rearmed: got %0d expected 2500", sig_out); end
    send(0, 3000, 1, 0);
    checks++;
    if (sig_out !== 16'sd2500) begin errors++; $display("FAIL tc_hold: got %0d expected 2500", sig_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) tuning_word = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
      in_valid  = ($urandom_range(4) != 0);
      in_ch     = 2'($urandom_range(3));
      sig_in    = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 16'sh7FFF : 16'sh8000) : 16'($urandom);
      shift     = 4'($urandom_range(15));
      mode      = 1'($urandom_range(1));
      out_ready = ($urandom_range(5) != 0);
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got %0b expected %0b", i, in_ready, (!m_valid || out_ready));
      end
      step();
      checks++;
      if (out_valid !== m_valid || (m_valid && (sig_out !== 16'(m_sig) || out_ch !== 2'(m_ch)))) begin
        errors++;
        $display("FAIL rnd_out[%0d]: valid=%0b sig=%0d ch=%0d expected %0b/%0d/%0d", i, out_valid, sig_out, out_ch, m_valid, m_sig, m_ch);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lp_step();
    test_frozen();
    test_hp_sat();
    test_back_to_back();
    test_tick_coincide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
